mux_circuit_sweeper: RTL and testbench

Self-checking sequencer for the two-function mux circuit (`simple_circuit_with_mux` style datapath: inputs a/b/c/x/y/z, mux_sel, one output). On a start pulse it drives all 16 input vectors (8 per mux_sel phase), samples the circuit output after a programmable settle time, and builds one 8-bit captured truth table per phase. It compares each table against a parameterised expected table and reports pass/fail and the mismatch count. It sits between a control source and the circuit, replacing hand-written vector sequencing.

---
 rtl/mux_circuit_sweeper.sv | 183 ++++++++++++++++++
 tb/tb_mux_circuit_sweeper.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_circuit_sweeper.sv
// Exhaustive vector sweeper and truth-table checker for the two-function mux circuit.
// Optional build macro SWEEPER_EARLY_ABORT_EN ends a sweep on its first mismatching sample.
module mux_circuit_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [7:0]  EXP0          = 8'hF4,
  parameter logic [7:0]  EXP1          = 8'h6F
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_start,
  input  logic       in_q,
  output logic       out_a,
  output logic       out_b,
  output logic       out_c,
  output logic       out_x,
  output logic       out_y,
  output logic       out_z,
  output logic       out_mux_sel,
  output logic       out_busy,
  output logic       out_done,
  output logic       out_pass,
  output logic [7:0] out_table0,
  output logic [7:0] out_table1,
  output logic [4:0] out_err_count
);

  localparam int unsigned VEC_W = 4;
  localparam int unsigned TBL_W = 8;
  localparam int unsigned ERR_W = 5;
  localparam int unsigned DRV_W = 7;
  localparam int unsigned SET_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES);
  localparam logic [VEC_W-1:0] VEC_LAST    = VEC_W'(15);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [VEC_W-1:0]   r_vec;
  logic [VEC_W-1:0]   w_vec_nxt;
  logic [SET_W-1:0]   r_settle;
  logic [SET_W-1:0]   w_settle_nxt;
  logic [TBL_W-1:0]   r_table0;
  logic [TBL_W-1:0]   w_table0_nxt;
  logic [TBL_W-1:0]   r_table1;
  logic [TBL_W-1:0]   w_table1_nxt;
  logic [ERR_W-1:0]   r_err;
  logic [ERR_W-1:0]   w_err_nxt;
  logic               r_pass;
  logic               w_pass_nxt;
  logic               r_busy;
  logic               r_done;
  logic [DRV_W-1:0]   r_drv;
  logic               w_sample;
  logic               w_exp_bit;
  logic               w_mismatch;
  logic               w_last;

  // Driver word layout {mux_sel, z, y, x, c, b, a}; phase 1 pins a=0, b=0, c=1.
  function automatic logic [DRV_W-1:0] drive_map(input logic [VEC_W-1:0] v);
    if (v[3]) begin
      return {1'b1, v[2:0], 3'b100};
    end
    return {1'b0, 3'b000, v[2:0]};
  endfunction

  assign w_sample   = (r_state == ST_RUN) && (r_settle == SETTLE_LAST);
  assign w_exp_bit  = r_vec[3] ? EXP1[r_vec[2:0]] : EXP0[r_vec[2:0]];
  assign w_mismatch = w_sample && (in_q != w_exp_bit);

`ifdef SWEEPER_EARLY_ABORT_EN
  assign w_last = (r_vec == VEC_LAST) || w_mismatch;
`else
  assign w_last = (r_vec == VEC_LAST);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next datapath values.
  always_comb begin
    w_state_nxt  = r_state;
    w_vec_nxt    = r_vec;
    w_settle_nxt = r_settle;
    w_table0_nxt = r_table0;
    w_table1_nxt = r_table1;
    w_err_nxt    = r_err;
    w_pass_nxt   = r_pass;

    case (r_state)
      ST_IDLE: begin
        if (in_start) begin
          w_state_nxt  = ST_RUN;
          w_vec_nxt    = '0;
          w_settle_nxt = '0;
          w_table0_nxt = '0;
          w_table1_nxt = '0;
          w_err_nxt    = '0;
          w_pass_nxt   = 1'b0;
        end
      end
      ST_RUN: begin
        if (!w_sample) begin
          w_settle_nxt = r_settle + SET_W'(1);
        end else begin
          if (r_vec[3]) begin
            w_table1_nxt[r_vec[2:0]] = in_q;
          end else begin
            w_table0_nxt[r_vec[2:0]] = in_q;
          end
          if (w_mismatch) begin
            w_err_nxt = r_err + ERR_W'(1);
          end
          w_settle_nxt = '0;
          if (w_last) begin
            w_state_nxt = ST_DONE;
            w_vec_nxt   = '0;
            w_pass_nxt  = (w_err_nxt == '0);
          end else begin
            w_vec_nxt = r_vec + VEC_W'(1);
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath and registered outputs; drivers follow the vector being loaded.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vec    <= '0;
      r_settle <= '0;
      r_table0 <= '0;
      r_table1 <= '0;
      r_err    <= '0;
      r_pass   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_drv    <= '0;
    end else begin
      r_vec    <= w_vec_nxt;
      r_settle <= w_settle_nxt;
      r_table0 <= w_table0_nxt;
      r_table1 <= w_table1_nxt;
      r_err    <= w_err_nxt;
      r_pass   <= w_pass_nxt;
      r_busy   <= (w_state_nxt == ST_RUN);
      r_done   <= (w_state_nxt == ST_DONE);
      r_drv    <= drive_map(w_vec_nxt);
    end
  end

  assign out_a         = r_drv[0];
  assign out_b         = r_drv[1];
  assign out_c         = r_drv[2];
  assign out_x         = r_drv[3];
  assign out_y         = r_drv[4];
  assign out_z         = r_drv[5];
  assign out_mux_sel   = r_drv[6];
  assign out_busy      = r_busy;
  assign out_done      = r_done;
  assign out_pass      = r_pass;
  assign out_table0    = r_table0;
  assign out_table1    = r_table1;
  assign out_err_count = r_err;

endmodule

// File: tb/tb_mux_circuit_sweeper.sv
// Scoreboard bench for mux_circuit_sweeper: default-settle instance plus a SETTLE_CYCLES=3 instance.
module tb_mux_circuit_sweeper;

  localparam logic [7:0] EXP0 = 8'hF4;
  localparam logic [7:0] EXP1 = 8'h6F;

  typedef struct {
    logic [7:0] t0;
    logic [7:0] t1;
    logic [4:0] err;
    logic       pass;
    int         busy;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1, start1, q1;
  logic       a1, b1, c1, x1, y1, z1, sel1, busy1, done1, pass1;
  logic [7:0] t0_1, t1_1;
  logic [4:0] err1;

  logic       rst2, start2, q2;
  logic       a2, b2, c2, x2, y2, z2, sel2, busy2, done2, pass2;
  logic [7:0] t0_2, t1_2;
  logic [4:0] err2;

  logic q1_stuck;
  logic q2_corrupt;
  int   e2;
  logic pb2;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q_exp1[$];
  exp_t q_exp2[$];
  int   bc1 = 0;
  int   bc2 = 0;

  mux_circuit_sweeper u_dut1 (
    .clk(clk), .reset(rst1), .in_start(start1), .in_q(q1),
    .out_a(a1), .out_b(b1), .out_c(c1), .out_x(x1), .out_y(y1), .out_z(z1),
    .out_mux_sel(sel1), .out_busy(busy1), .out_done(done1), .out_pass(pass1),
    .out_table0(t0_1), .out_table1(t1_1), .out_err_count(err1)
  );

  mux_circuit_sweeper #(.SETTLE_CYCLES(3)) u_dut2 (
    .clk(clk), .reset(rst2), .in_start(start2), .in_q(q2),
    .out_a(a2), .out_b(b2), .out_c(c2), .out_x(x2), .out_y(y2), .out_z(z2),
    .out_mux_sel(sel2), .out_busy(busy2), .out_done(done2), .out_pass(pass2),
    .out_table0(t0_2), .out_table1(t1_2), .out_err_count(err2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour of a correct circuit under test.
  function automatic logic circuit(input logic sel, input logic a, input logic b, input logic c,
                                   input logic x, input logic y, input logic z);
    logic [7:0] t0;
    logic [7:0] t1;
    t0 = EXP0;
    t1 = EXP1;
    return sel ? t1[{z, y, x}] : t0[{c, b, a}];
  endfunction

  always_comb begin
    q1 = q1_stuck ? 1'b0 : circuit(sel1, a1, b1, c1, x1, y1, z1);
  end

  // Instance 2 sees the wrong answer except on the cycle just before each sample edge.
  always_comb begin
    q2 = circuit(sel2, a2, b2, c2, x2, y2, z2);
    if (q2_corrupt && busy2 && (((e2 + 1) % 4) != 0)) q2 = ~q2;
  end

  always @(negedge clk) begin
    if (busy2) e2 <= pb2 ? e2 + 1 : 0;
    pb2 <= busy2;
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst1) begin
      bc1 = 0;
    end else begin
      if (busy1) bc1++;
      if (done1) begin
        if (q_exp1.size() == 0) begin
          check("dut1_unexpected_done", 32'(1), 32'(0));
        end else begin
          e = q_exp1.pop_front();
          check("dut1_table0", 32'(t0_1), 32'(e.t0));
          check("dut1_table1", 32'(t1_1), 32'(e.t1));
          check("dut1_err_count", 32'(err1), 32'(e.err));
          check("dut1_pass", 32'(pass1), 32'(e.pass));
          check("dut1_busy_cycles", 32'(bc1), 32'(e.busy));
          check("dut1_busy_in_done", 32'(busy1), 32'(0));
        end
        bc1 = 0;
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (rst2) begin
      bc2 = 0;
    end else begin
      if (busy2) bc2++;
      if (done2) begin
        if (q_exp2.size() == 0) begin
          check("dut2_unexpected_done", 32'(1), 32'(0));
        end else begin
          e = q_exp2.pop_front();
          check("dut2_table0", 32'(t0_2), 32'(e.t0));
          check("dut2_table1", 32'(t1_2), 32'(e.t1));
          check("dut2_err_count", 32'(err2), 32'(e.err));
          check("dut2_pass", 32'(pass2), 32'(e.pass));
          check("dut2_busy_cycles", 32'(bc2), 32'(e.busy));
        end
        bc2 = 0;
      end
    end
  end

  task automatic push1(input logic [7:0] t0, input logic [7:0] t1, input logic [4:0] err,
                       input logic pass, input int busy);
    exp_t e;
    e.t0 = t0; e.t1 = t1; e.err = err; e.pass = pass; e.busy = busy;
    q_exp1.push_back(e);
  endtask

  task automatic wait_done(input int which, input int lim);
    int n = 0;
    while (((which == 2) ? done2 : done1) !== 1'b1 && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (((which == 2) ? done2 : done1) !== 1'b1) check("done_timeout", 32'(0), 32'(1));
  endtask

  task automatic pulse_start1();
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
  endtask

  initial begin
    exp_t e;
    rst1 = 1'b1; rst2 = 1'b1; start1 = 1'b0; start2 = 1'b0;
    q1_stuck = 1'b0; q2_corrupt = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("dut1_reset_outputs",
          32'({a1, b1, c1, x1, y1, z1, sel1, busy1, done1, pass1, t0_1, t1_1, err1}), 32'(0));
    check("dut2_reset_outputs",
          32'({a2, b2, c2, x2, y2, z2, sel2, busy2, done2, pass2, t0_2, t1_2, err2}), 32'(0));
    @(posedge clk); #1;
    rst1 = 1'b0; rst2 = 1'b0;
    @(posedge clk); #1;

    // Good circuit, default settle.
    push1(EXP0, EXP1, 5'd0, 1'b1, 32);
    pulse_start1();
    wait_done(1, 100);
    @(posedge clk); #1;
    repeat (2) @(negedge clk);
    check("s1_hold_table0", 32'(t0_1), 32'(EXP0));
    check("s1_hold_pass", 32'(pass1), 32'(1));
    @(posedge clk); #1;

    // Output stuck at 0.
    q1_stuck = 1'b1;
`ifdef SWEEPER_EARLY_ABORT_EN
    push1(8'h00, 8'h00, 5'd1, 1'b0, 6);
`else
    push1(8'h00, 8'h00, 5'd11, 1'b0, 32);
`endif
    pulse_start1();
    wait_done(1, 100);
    @(posedge clk); #1;
    q1_stuck = 1'b0;
    @(posedge clk); #1;

    // Start held high: back-to-back sweeps with one idle cycle between.
    for (int s = 0; s < 3; s++) push1(EXP0, EXP1, 5'd0, 1'b1, 32);
    start1 = 1'b1;
    for (int s = 0; s < 3; s++) begin
      wait_done(1, 100);
      @(negedge clk);
      check("s3_gap_busy", 32'(busy1), 32'(0));
      check("s3_gap_done", 32'(done1), 32'(0));
      @(negedge clk);
      check("s3_restart_busy", 32'(busy1), (s < 2) ? 32'(1) : 32'(0));
      if (s == 1) begin
        @(posedge clk); #1;
        start1 = 1'b0;
      end
    end
    @(posedge clk); #1;

    // Reset while vec=5.
    pulse_start1();
    repeat (10) @(posedge clk);
    #1;
    check("s4_vec5_drivers", 32'({sel1, c1, b1, a1}), 32'(4'b0101));
    check("s4_busy_before_reset", 32'(busy1), 32'(1));
    rst1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("s4_reset_outputs",
          32'({a1, b1, c1, x1, y1, z1, sel1, busy1, done1, pass1, t0_1, t1_1, err1}), 32'(0));
    @(posedge clk); #1;
    rst1 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    push1(EXP0, EXP1, 5'd0, 1'b1, 32);
    pulse_start1();
    wait_done(1, 100);
    @(posedge clk); #1;

    // SETTLE_CYCLES=3 with in_q wrong on every non-sample cycle.
    q2_corrupt = 1'b1;
    e.t0 = EXP0; e.t1 = EXP1; e.err = 5'd0; e.pass = 1'b1; e.busy = 64;
    q_exp2.push_back(e);
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    wait_done(2, 200);
    @(posedge clk); #1;
    q2_corrupt = 1'b0;

    repeat (4) @(posedge clk);
    #1;
    check("dut1_queue_empty", 32'(q_exp1.size()), 32'(0));
    check("dut2_queue_empty", 32'(q_exp2.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
